rob_retire_unit: RTL

- In-order reorder buffer and retirement stage; the producer side of the register file's 4-lane retirement write port.
- Dispatch allocates up to 4 entries per cycle and receives a 4-bit tag per entry. That tag is the register owner ID recorded when the destination is marked busy.
- Two result-bus ports mark entries done out of order.
- Each cycle, up to 4 oldest consecutive done entries retire in program order. For each, the unit drives retirement_write_data_enable, retirement_target_reg, retirement_write_data and instruction_writer on lanes 0..3.

---
 rtl/rob_retire_if.sv | 40 ++++
 rtl/rob_retire_unit.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/rob_retire_if.sv
// Dispatch, completion-bus and retirement-port signals of rob_retire_unit.
// master = dispatch/execute side driving the unit, slave = the reorder buffer itself.
interface rob_retire_if #(
    parameter int TAG_W  = 4,
    parameter int DATA_W = 16
);
    // Allocation handshake: lanes in alloc_valid are accepted at a clock edge only when
    // alloc_ready is high in that cycle and alloc_valid is a contiguous prefix from lane 0;
    // alloc_tag[i] is the tag that lane i receives if accepted.
    logic [3:0]              alloc_valid;
    logic [3:0]              alloc_has_dest;
    logic [3:0][3:0]         alloc_dest_reg;
    logic                    alloc_ready;
    logic [3:0][TAG_W-1:0]   alloc_tag;
    logic [1:0]              cdb_valid;
    logic [1:0][TAG_W-1:0]   cdb_tag;
    logic [1:0][DATA_W-1:0]  cdb_value;
    logic                    flush;
    logic [3:0]              retirement_write_data_enable;
    logic [3:0][3:0]         retirement_target_reg;
    logic [3:0][DATA_W-1:0]  retirement_write_data;
    logic [3:0][TAG_W-1:0]   instruction_writer;
    logic                    rob_empty;

    modport master (
        output alloc_valid, alloc_has_dest, alloc_dest_reg,
        output cdb_valid, cdb_tag, cdb_value, flush,
        input  alloc_ready, alloc_tag, rob_empty,
        input  retirement_write_data_enable, retirement_target_reg,
        input  retirement_write_data, instruction_writer
    );

    modport slave (
        input  alloc_valid, alloc_has_dest, alloc_dest_reg,
        input  cdb_valid, cdb_tag, cdb_value, flush,
        output alloc_ready, alloc_tag, rob_empty,
        output retirement_write_data_enable, retirement_target_reg,
        output retirement_write_data, instruction_writer
    );
endinterface

// File: rtl/rob_retire_unit.sv
// 16-entry in-order reorder buffer with 4-wide allocate, 2 completion ports and 4-wide retirement.
// Optional head-stall cycle counter enabled by defining ROB_STALL_STATS_EN.
module rob_retire_unit #(
    parameter int DEPTH  = 16,
    parameter int TAG_W  = 4,
    parameter int DATA_W = 16
) (
    input  logic        clk,
    input  logic        rst_n,
`ifdef ROB_STALL_STATS_EN
    output logic [15:0] stall_cycles,
`endif
    rob_retire_if.slave bus
);
    localparam logic [TAG_W:0] ALLOC_MAX = (TAG_W+1)'(DEPTH - 4);

    logic [DEPTH-1:0]        r_valid;
    logic [DEPTH-1:0]        r_done;
    logic [DEPTH-1:0]        r_has_dest;
    logic [3:0]              r_dest  [DEPTH];
    logic [DATA_W-1:0]       r_value [DEPTH];
    logic [TAG_W-1:0]        r_head;
    logic [TAG_W-1:0]        r_tail;
    logic [TAG_W:0]          r_count;

    logic [3:0]              r_ret_en;
    logic [3:0][3:0]         r_ret_target;
    logic [3:0][DATA_W-1:0]  r_ret_data;
    logic [3:0][TAG_W-1:0]   r_ret_writer;

    logic                    w_alloc_fire;
    logic [2:0]              w_n_alloc;
    logic [3:0]              w_ret;
    logic [2:0]              w_n_ret;
    logic [TAG_W-1:0]        w_ridx [4];

    // Readiness uses the count before this cycle's retirement, so freed slots show up next cycle.
    assign bus.alloc_ready = (r_count <= ALLOC_MAX);
    assign bus.rob_empty   = (r_count == '0);
    assign w_alloc_fire    = bus.alloc_ready && bus.alloc_valid[0];

    assign bus.retirement_write_data_enable = r_ret_en;
    assign bus.retirement_target_reg        = r_ret_target;
    assign bus.retirement_write_data        = r_ret_data;
    assign bus.instruction_writer           = r_ret_writer;

    always_comb begin
        w_n_alloc = 3'd0;
        if (w_alloc_fire) begin
            w_n_alloc = 3'd1;
            if (bus.alloc_valid[1]) w_n_alloc = 3'd2;
            if (bus.alloc_valid[2:1] == 2'b11) w_n_alloc = 3'd3;
            if (bus.alloc_valid[3:1] == 3'b111) w_n_alloc = 3'd4;
        end
        for (int i = 0; i < 4; i++) begin
            bus.alloc_tag[i] = r_tail + TAG_W'(i);
        end
    end

    // Retire the longest run of valid+done entries starting at head, at most four.
    always_comb begin
        logic w_run;
        w_run   = 1'b1;
        w_n_ret = 3'd0;
        for (int j = 0; j < 4; j++) begin
            w_ridx[j] = r_head + TAG_W'(j);
            w_run     = w_run && r_valid[w_ridx[j]] && r_done[w_ridx[j]];
            w_ret[j]  = w_run;
            if (w_run) w_n_ret = w_n_ret + 3'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid    <= '0;
            r_done     <= '0;
            r_has_dest <= '0;
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_dest[i]  <= '0;
                r_value[i] <= '0;
            end
        end else if (bus.flush) begin
            r_valid <= '0;
            r_done  <= '0;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            // Port 1 first so that port 0 overrides it on a shared tag.
            for (int k = 1; k >= 0; k--) begin
                if (bus.cdb_valid[k] && r_valid[bus.cdb_tag[k]]) begin
                    r_done[bus.cdb_tag[k]]  <= 1'b1;
                    r_value[bus.cdb_tag[k]] <= bus.cdb_value[k];
                end
            end
            for (int j = 0; j < 4; j++) begin
                if (w_ret[j]) r_valid[w_ridx[j]] <= 1'b0;
            end
            if (w_alloc_fire) begin
                for (int i = 0; i < 4; i++) begin
                    if (bus.alloc_valid[i]) begin
                        r_valid[r_tail + TAG_W'(i)]    <= 1'b1;
                        r_done[r_tail + TAG_W'(i)]     <= 1'b0;
                        r_has_dest[r_tail + TAG_W'(i)] <= bus.alloc_has_dest[i];
                        r_dest[r_tail + TAG_W'(i)]     <= bus.alloc_dest_reg[i];
                    end
                end
            end
            r_head  <= r_head + TAG_W'(w_n_ret);
            r_tail  <= r_tail + TAG_W'(w_n_alloc);
            r_count <= r_count + (TAG_W+1)'(w_n_alloc) - (TAG_W+1)'(w_n_ret);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ret_en     <= '0;
            r_ret_target <= '0;
            r_ret_data   <= '0;
            r_ret_writer <= '0;
        end else if (bus.flush) begin
            r_ret_en <= '0;
        end else begin
            for (int j = 0; j < 4; j++) begin
                r_ret_en[j] <= w_ret[j] && r_has_dest[w_ridx[j]];
                if (w_ret[j]) begin
                    r_ret_target[j] <= r_dest[w_ridx[j]];
                    r_ret_data[j]   <= r_value[w_ridx[j]];
                    r_ret_writer[j] <= w_ridx[j];
                end
            end
        end
    end

`ifdef ROB_STALL_STATS_EN
    logic [15:0] r_stall_cycles;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cycles <= '0;
        end else if (bus.flush) begin
            r_stall_cycles <= '0;
        end else if (r_count != '0 && !r_done[r_head] && r_stall_cycles != 16'hFFFF) begin
            r_stall_cycles <= r_stall_cycles + 16'd1;
        end
    end

    assign stall_cycles = r_stall_cycles;
`endif

    a_alloc_prefix: assert property (@(posedge clk) disable iff (!rst_n)
        ((bus.alloc_valid & (bus.alloc_valid + 4'd1)) == 4'd0))
        else $error("rob_retire_unit: non-prefix alloc_valid %b", bus.alloc_valid);

endmodule
